boot_rom_req_adapter: RTL and testbench
=======================================

Name: boot_rom_req_adapter

Overview:
Request-side adapter that sits directly upstream of the HDAC boot ROM macro. It accepts word-aligned read requests from the SoC interconnect and range-checks them against the ROM window. It translates in-range reads into ROM chip-select/address strobes and returns ordered responses with ID and error flag through a ready/valid response channel. It also sequences the ROM init strobe after reset and rejects writes and out-of-window accesses with an error response.

Parameters:
ROM_ADDR_WIDTH, 13, number of ROM word-address bits; window size = 4*2^ROM_ADDR_WIDTH bytes
AddrOffset, 32'h1a000000, byte base address of ROM window
ID_WIDTH, 4, request/response transaction ID width
RESP_DEPTH, 3, response buffer entries (legal range 2..8)
INIT_CYCLES, 4, cycles rom_init_no is held low after reset release (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  request valid
gnt_o  out  1  request accepted this cycle (req_i && gnt_o = handshake)
add_i  in  32  byte address
we_i  in  1  1 = write (always errors), 0 = read
be_i  in  4  byte enables (ignored for reads; carried for protocol only)
id_i  in  ID_WIDTH  transaction ID
r_valid_o  out  1  response valid
r_ready_i  in  1  response consumer ready
r_rdata_o  out  32  read data (0 on error)
r_id_o  out  ID_WIDTH  ID of response
r_err_o  out  1  1 = write or out-of-window access
rom_init_no  out  1  ROM init strobe, active low
rom_csn_o  out  1  ROM chip select, active low
rom_add_o  out  32  ROM word address, zero-extended
rom_rdata_i  in  32  ROM read data, valid the cycle after rom_csn_o low

Behaviour:
- Reset values: gnt_o=0, r_valid_o=0, r_rdata_o=0, r_id_o=0, r_err_o=0, rom_init_no=0, rom_csn_o=1, rom_add_o=0. The buffer is emptied, the in-flight stage is cleared and the init counter is reloaded.
- Init FSM: INIT -> READY. In INIT, rom_init_no=0 and gnt_o=0; a counter runs for INIT_CYCLES cycles after rst_ni deasserts. In READY, rom_init_no=1 and stays there until the next reset.
- Grant: gnt_o = READY && req_i && (inflight + count < RESP_DEPTH). gnt_o has no combinational dependence on r_ready_i.
- In-window test: AddrOffset <= add_i < AddrOffset + 4*2^ROM_ADDR_WIDTH, with unsigned arithmetic evaluated at 33 bits so no wrap occurs at 2^32.
- Accepted in-window read in cycle N: rom_csn_o=0 and rom_add_o = (add_i - AddrOffset)>>2, both combinational in cycle N.
- Accepted write or out-of-window access: rom_csn_o stays 1, and the error flag is carried through the pipeline.
- add_i[1:0] is ignored; the access is word-granular.
- Cycle N+1: the in-flight stage holds {id, err}. Data = err ? 0 : rom_rdata_i. The entry is pushed into the FIFO at the end of N+1.
- Cycle N+2: earliest r_valid_o. Responses come from the FIFO head (registered outputs).
- Latency is fixed at 2 cycles for both error and ROM responses, so order is strictly preserved.
- Throughput: 1 request/cycle sustained while r_ready_i=1. With r_ready_i=0, grants stop once inflight + count = RESP_DEPTH.
- Response: r_valid_o = (count > 0). Pop on r_valid_o && r_ready_i. r_rdata_o/r_id_o/r_err_o are stable while r_valid_o && !r_ready_i.
- Push and pop in the same cycle: count is unchanged and the FIFO pointers wrap modulo RESP_DEPTH.
- A push is never dropped; the credit check guarantees space for it.
- Reset mid-operation: all in-flight and buffered responses are discarded with no r_valid_o afterwards, and the FSM re-enters INIT.
- No requests are granted during INIT. req_i may be held; it is granted the first READY cycle.

Test Plan:
- Reset with INIT_CYCLES=4: rst_ni rises at cycle 0 -> rom_init_no=0 and gnt_o=0 for cycles 0..3, rom_init_no=1 from cycle 4. A req_i held since cycle 0 is granted in cycle 4 with rom_csn_o=0.
- Read add_i=32'h1a000010, id=3, ROM returns 32'hdeadbeef -> rom_add_o=4 in the grant cycle; two cycles later r_valid_o=1, r_rdata_o=32'hdeadbeef, r_id_o=3, r_err_o=0.
- Error cases: write to 32'h1a000000; read 32'h1a008000 (first address past the window); read 32'h19fffffc -> rom_csn_o stays 1 and each returns r_err_o=1, r_rdata_o=0 at 2-cycle latency. Read 32'h1a007ffc -> in window, rom_add_o=32'h1fff.
- Back-to-back 8 reads, IDs 0..7, r_ready_i=1 -> one grant per cycle, responses on 8 consecutive cycles in ID order.
- Backpressure: r_ready_i=0 with req_i continuously high -> exactly 3 grants, then gnt_o=0 with r_valid_o held and data stable. Raise r_ready_i -> responses drain in order and grants resume.
- Assert rst_ni=0 with 2 responses buffered and 1 in flight -> the outputs return to their reset values and no stale r_valid_o appears after INIT completes.

Source files
------------

// File: rtl/boot_rom_req_adapter_if.sv
// rtl/boot_rom_req_adapter_if.sv - request/response bus between the SoC interconnect and the boot ROM adapter
interface boot_rom_req_adapter_if #(
  parameter int unsigned ID_WIDTH = 4
) ();
  logic                req_i;
  logic                gnt_o;
  logic [31:0]         add_i;
  logic                we_i;
  logic [3:0]          be_i;
  logic [ID_WIDTH-1:0] id_i;
  logic                r_valid_o;
  logic                r_ready_i;
  logic [31:0]         r_rdata_o;
  logic [ID_WIDTH-1:0] r_id_o;
  logic                r_err_o;

  modport master (
    output req_i, add_i, we_i, be_i, id_i, r_ready_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_id_o, r_err_o
  );

  modport slave (
    input  req_i, add_i, we_i, be_i, id_i, r_ready_i,
    output gnt_o, r_valid_o, r_rdata_o, r_id_o, r_err_o
  );
endinterface

// File: rtl/boot_rom_req_adapter.sv
// rtl/boot_rom_req_adapter.sv - boot ROM request adapter: window check, ROM strobes, ordered responses
module boot_rom_req_adapter #(
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] AddrOffset     = 32'h1a000000,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned RESP_DEPTH     = 3,
  parameter int unsigned INIT_CYCLES    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  boot_rom_req_adapter_if.slave        bus,
  output logic                         rom_init_no,
  output logic                         rom_csn_o,
  output logic [31:0]                  rom_add_o,
  input  logic [31:0]                  rom_rdata_i
);

  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [32:0] WinBase = {1'b0, AddrOffset};
  localparam logic [32:0] WinEnd  = WinBase + (33'd4 << ROM_ADDR_WIDTH);

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  init_cnt_q, init_cnt_d;
  logic           ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_INIT;
      init_cnt_q <= IW'(INIT_CYCLES - 1);
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rom_init_no = 1'b0;
    ready       = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == '0) state_d = S_READY;
        else                  init_cnt_d = init_cnt_q - 1'b1;
      end
      S_READY: begin
        rom_init_no = 1'b1;
        ready       = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  logic                inf_valid_q, inf_err_q;
  logic [ID_WIDTH-1:0] inf_id_q;
  logic [CW-1:0]       count_q;
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW:0]         occupancy;
  logic [32:0]         add_ext;
  logic [31:0]         win_off;
  logic                in_win, rom_rd, req_err, push, pop;
  logic                unused_bits;

  // Window compare at 33 bits so a window ending at 2^32 cannot wrap.
  assign add_ext   = {1'b0, bus.add_i};
  assign in_win    = (add_ext >= WinBase) && (add_ext < WinEnd);
  assign win_off   = bus.add_i - AddrOffset;
  assign req_err   = bus.we_i || !in_win;
  // Credits count the in-flight slot so its push always finds room.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inf_valid_q);
  assign bus.gnt_o = ready && bus.req_i && (occupancy < (CW+1)'(RESP_DEPTH));
  assign rom_rd    = bus.gnt_o && !req_err;
  assign rom_csn_o = !rom_rd;
  assign rom_add_o = rom_rd ? 32'(win_off[ROM_ADDR_WIDTH+1:2]) : 32'h0;
  assign unused_bits = ^{bus.be_i, win_off[1:0], win_off[31:ROM_ADDR_WIDTH+2]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inf_valid_q <= 1'b0;
      inf_err_q   <= 1'b0;
      inf_id_q    <= '0;
    end else begin
      inf_valid_q <= bus.gnt_o;
      inf_err_q   <= req_err;
      inf_id_q    <= bus.id_i;
    end
  end

  logic [31:0]         mem_data [RESP_DEPTH];
  logic [ID_WIDTH-1:0] mem_id   [RESP_DEPTH];
  logic                mem_err  [RESP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push = inf_valid_q;
  assign pop  = (count_q != '0) && bus.r_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wptr_q] <= inf_err_q ? 32'h0 : rom_rdata_i;
        mem_id[wptr_q]   <= inf_id_q;
        mem_err[wptr_q]  <= inf_err_q;
        wptr_q           <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.r_valid_o = (count_q != '0);
  assign bus.r_rdata_o = bus.r_valid_o ? mem_data[rptr_q] : 32'h0;
  assign bus.r_id_o    = bus.r_valid_o ? mem_id[rptr_q] : '0;
  assign bus.r_err_o   = bus.r_valid_o && mem_err[rptr_q];

endmodule

// File: tb/tb_boot_rom_req_adapter.sv
// tb/tb_boot_rom_req_adapter.sv - directed scoreboard bench for boot_rom_req_adapter
module tb_boot_rom_req_adapter;
  localparam logic [31:0] BASE = 32'h1a000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boot_rom_req_adapter_if #(.ID_WIDTH(4)) bus ();
  logic        rom_init_no, rom_csn_o;
  logic [31:0] rom_add_o;
  logic [31:0] rom_rdata_i = 32'h0;

  boot_rom_req_adapter #(
    .ROM_ADDR_WIDTH(13), .AddrOffset(BASE), .ID_WIDTH(4), .RESP_DEPTH(3), .INIT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .rom_init_no(rom_init_no), .rom_csn_o(rom_csn_o),
    .rom_add_o(rom_add_o), .rom_rdata_i(rom_rdata_i)
  );

  typedef struct {
    logic [3:0]  id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   resp_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd4) return 32'hdeadbeef;
    return {16'hc0de, a[15:0]};
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    logic [32:0] x;
    x = {1'b0, a};
    return (x >= 33'h01a000000) && (x < 33'h01a008000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ROM macro: data valid the cycle after a chip-select
  always @(posedge clk)
    rom_rdata_i <= !rom_csn_o ? rom_word(rom_add_o) : 32'hbad0bad0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.r_valid_o && bus.r_ready_i) begin
      exp_t e;
      chk("resp_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("resp_id", 32'(bus.r_id_o), 32'(e.id));
        chk("resp_err", 32'(bus.r_err_o), 32'(e.err));
        chk("resp_data", bus.r_rdata_o, e.data);
      end
      resp_cyc.push_back(cyc);
    end
  end

  task automatic push_exp(input logic [31:0] addr, input logic we, input logic [3:0] id);
    exp_t e;
    e.id   = id;
    e.err  = we || !in_win(addr);
    e.data = e.err ? 32'h0 : rom_word((addr - BASE) >> 2);
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] id, output int gcyc);
    int n;
    logic rd;
    bus.req_i = 1'b1; bus.add_i = addr; bus.we_i = we; bus.id_i = id;
    bus.be_i = we ? 4'hf : 4'h0;
    n = 0;
    @(negedge clk);
    while (bus.gnt_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    chk("grant", 32'(bus.gnt_o), 32'd1);
    rd = in_win(addr) && !we;
    chk("rom_csn", 32'(rom_csn_o), 32'(!rd));
    if (rd) chk("rom_add", rom_add_o, (addr - BASE) >> 2);
    push_exp(addr, we, id);
    gcyc = cyc;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
  endtask

  task automatic lat_chk(input string tag);
    @(negedge clk);
    chk({tag, "_n1"}, 32'(bus.r_valid_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_n2"}, 32'(bus.r_valid_o), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int gb[8];
    int ngr;
    logic [3:0] nid;
    logic [31:0] a;

    bus.req_i = 1'b1; bus.add_i = 32'h1a000010; bus.we_i = 1'b0;
    bus.be_i = 4'h0; bus.id_i = 4'd3; bus.r_ready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 0);
    chk("rst_rvalid", 32'(bus.r_valid_o), 0);
    chk("rst_rdata", bus.r_rdata_o, 0);
    chk("rst_rid", 32'(bus.r_id_o), 0);
    chk("rst_rerr", 32'(bus.r_err_o), 0);
    chk("rst_init_n", 32'(rom_init_no), 0);
    chk("rst_csn", 32'(rom_csn_o), 1);
    chk("rst_add", rom_add_o, 0);

    // Release reset with the request already pending
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_low", 32'(rom_init_no), 0);
      chk("init_no_gnt", 32'(bus.gnt_o), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("init_done", 32'(rom_init_no), 1);
    chk("first_gnt", 32'(bus.gnt_o), 1);
    chk("first_csn", 32'(rom_csn_o), 0);
    chk("first_add", rom_add_o, 32'd4);
    push_exp(32'h1a000010, 1'b0, 4'd3);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    lat_chk("lat_read");

    issue(32'h1a000000, 1'b1, 4'd5, g); lat_chk("lat_write");
    issue(32'h1a008000, 1'b0, 4'd6, g); lat_chk("lat_past_end");
    issue(32'h19fffffc, 1'b0, 4'd7, g); lat_chk("lat_below");
    issue(32'h1a007ffc, 1'b0, 4'd8, g); lat_chk("lat_last_word");
    chk("rom_add_last", rom_add_o, 32'h0);

    // Back-to-back burst
    resp_cyc.delete();
    for (int i = 0; i < 8; i++) issue(BASE + 32'(i * 4), 1'b0, 4'(i), gb[i]);
    for (int i = 1; i < 8; i++) chk("burst_gnt_cyc", 32'(gb[i] - gb[i-1]), 32'd1);
    drain("burst_drain");
    chk("burst_resp_cnt", 32'(resp_cyc.size()), 32'd8);
    chk("burst_first_lat", 32'(resp_cyc[0] - gb[0]), 32'd2);
    chk("burst_span", 32'(resp_cyc[7] - resp_cyc[0]), 32'd7);

    // Backpressure
    bus.r_ready_i = 1'b0;
    bus.req_i = 1'b1; bus.we_i = 1'b0;
    nid = 4'd9; ngr = 0;
    for (int c = 0; c < 8; c++) begin
      a = BASE + 32'h40 + 32'(nid) * 4;
      bus.add_i = a; bus.id_i = nid;
      @(negedge clk);
      if (bus.gnt_o === 1'b1) begin
        push_exp(a, 1'b0, nid);
        ngr++; nid++;
      end
      @(posedge clk); #1;
    end
    chk("bp_grants", 32'(ngr), 32'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_gnt_low", 32'(bus.gnt_o), 0);
      chk("bp_valid_held", 32'(bus.r_valid_o), 1);
      chk("bp_id_stable", 32'(bus.r_id_o), 32'(sbq[0].id));
      chk("bp_data_stable", bus.r_rdata_o, sbq[0].data);
      @(posedge clk); #1;
    end
    bus.r_ready_i = 1'b1;
    ngr = 0;
    for (int c = 0; c < 10 && ngr == 0; c++) begin
      a = BASE + 32'h40 + 32'(nid) * 4;
      bus.add_i = a; bus.id_i = nid;
      @(negedge clk);
      if (bus.gnt_o === 1'b1) begin
        push_exp(a, 1'b0, nid);
        ngr++;
      end
      @(posedge clk); #1;
    end
    bus.req_i = 1'b0;
    chk("bp_resume", 32'(ngr), 32'd1);
    drain("bp_drain");

    // Reset with two buffered and one in flight
    bus.r_ready_i = 1'b0;
    issue(BASE + 32'h100, 1'b0, 4'd1, g);
    issue(BASE + 32'h104, 1'b0, 4'd2, g);
    issue(BASE + 32'h108, 1'b0, 4'd3, g);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mrst_gnt", 32'(bus.gnt_o), 0);
    chk("mrst_rvalid", 32'(bus.r_valid_o), 0);
    chk("mrst_rdata", bus.r_rdata_o, 0);
    chk("mrst_rid", 32'(bus.r_id_o), 0);
    chk("mrst_rerr", 32'(bus.r_err_o), 0);
    chk("mrst_init_n", 32'(rom_init_no), 0);
    chk("mrst_csn", 32'(rom_csn_o), 1);
    chk("mrst_add", rom_add_o, 0);
    bus.r_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.r_valid_o), 0);
      chk("post_rst_init", 32'(rom_init_no), 32'(c >= 4));
      @(posedge clk); #1;
    end
    issue(BASE + 32'h8, 1'b0, 4'ha, g);
    lat_chk("post_rst_read");
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
